// File: rtl/mem_pkg.sv
// Shared definitions for the byte-banked data memory: funct3 size codes,
// controller state encoding, the latched-request record and lane helpers.
package mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  // Request held across the two beats of a word-crossing access.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  function automatic logic size_legal(input logic [2:0] sz);
    return sz inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Lanes touched by an access, wrapping past lane 3 back to lane 0.
  function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] lane);
    logic [7:0] m;
    case (sz[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    m = m << lane;
    return m[3:0] | m[7:4];
  endfunction

  function automatic logic crosses_word(input logic [2:0] sz, input logic [1:0] lane);
    return ({1'b0, lane} + size_bytes(sz)) > 3'd4;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One byte lane of the data memory: synchronous write, registered read.
module mem_bank #(
   parameter int    DEPTH       = 1024,
   parameter string INIT_PREFIX = "",
   parameter int    LANE        = 0
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata
);

   logic [7:0] mem [DEPTH];

   // Write and read port share the address; rdata only moves when re is set.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-banked RISC-V data memory with valid/ready requests and a registered
// one-cycle response pulse. Define MISALIGNED_EN to split word-crossing
// accesses into two beats; otherwise they are answered with rsp_err.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | ready; accepts one request per cycle
//   ST_SPLIT | second beat of a word-crossing access (MISALIGNED_EN only)
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int    DATA_BYTES  = 4096,
  parameter string INIT_PREFIX = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DATA_BYTES);
  localparam int WW = AW - 2;

  logic [0:0]    state;
  req_t          held;
  logic          accept, go_split, mis_err;
  logic [31:0]   cur_addr, cur_wdata;
  logic [2:0]    cur_size;
  logic [WW-1:0] cur_w;
  logic [1:0]    cur_l;
  logic          cur_legal, cur_mis;
  logic [3:0]    cur_mask, low_mask;
  logic [63:0]   wd_dbl, rd_dbl;
  logic [31:0]   wd_rot, rd_rot, bank_q;
  logic [3:0]    bank_we, bank_re;
  logic [WW-1:0] bank_addr [4];
  logic          rsp_load;
  logic [2:0]    rsp_size;
  logic [1:0]    rsp_lane;
  logic          unused_ok;

  assign accept = req_valid && req_ready;

  // During SPLIT the held request drives the lanes; otherwise the live port.
  assign cur_addr  = (state == ST_SPLIT) ? held.addr  : req_addr;
  assign cur_size  = (state == ST_SPLIT) ? held.size  : req_size;
  assign cur_wdata = (state == ST_SPLIT) ? held.wdata : req_wdata;
  assign cur_w     = cur_addr[AW-1:2];
  assign cur_l     = cur_addr[1:0];
  assign cur_legal = size_legal(cur_size);
  assign cur_mis   = crosses_word(cur_size, cur_l);
  assign cur_mask  = lane_mask(cur_size, cur_l);
  assign low_mask  = (4'd1 << cur_l) - 4'd1;
  assign wd_dbl    = {cur_wdata, cur_wdata} << {cur_l, 3'b000};
  assign wd_rot    = wd_dbl[63:32];

  assign unused_ok = ^{req_addr[31:AW], held.addr[31:AW]};

`ifdef MISALIGNED_EN
  assign req_ready = (state == ST_IDLE);
  assign mis_err   = 1'b0;
  assign go_split  = accept && cur_legal && cur_mis;

  // Two-beat sequencing for word-crossing accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    state <= ST_IDLE;
    else if (state == ST_SPLIT) state <= ST_IDLE;
    else if (go_split)          state <= ST_SPLIT;
  end

  // Capture the request so the second beat can run with req_ready low.
  always_ff @(posedge clk) begin
    if (go_split) held <= '{addr: req_addr, size: req_size, we: req_we, wdata: req_wdata};
  end
`else
  assign state     = ST_IDLE;
  assign held      = '0;
  assign req_ready = 1'b1;
  assign mis_err   = cur_legal && cur_mis;
  assign go_split  = 1'b0;
`endif

  // Bank strobes. Split loads read all lanes on the second edge, with the
  // wrapped lanes pointed at the next word, so bank_q never changes between
  // responses and rsp_rdata holds.
  always_comb begin
    bank_we = '0;
    bank_re = '0;
    for (int i = 0; i < 4; i++) bank_addr[i] = cur_w;
    if (state == ST_SPLIT) begin
      for (int i = 0; i < 4; i++) if (low_mask[i]) bank_addr[i] = cur_w + WW'(1);
      if (held.we) bank_we = cur_mask & low_mask;
      else         bank_re = 4'hF;
    end else if (accept && cur_legal && !mis_err) begin
      if (req_we)        bank_we = cur_mask & ~low_mask;
      else if (!cur_mis) bank_re = 4'hF;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    mem_bank #(.DEPTH(DATA_BYTES / 4), .INIT_PREFIX(INIT_PREFIX), .LANE(g)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .re    (bank_re[g]),
      .addr  (bank_addr[g]),
      .wdata (wd_rot[8*g +: 8]),
      .rdata (bank_q[8*g +: 8])
    );
  end

  // Response pulse plus the format of the load that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
      rsp_size  <= SZ_B;
      rsp_lane  <= 2'd0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == ST_SPLIT) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_load  <= !held.we;
        rsp_size  <= held.size;
        rsp_lane  <= held.addr[1:0];
      end else if (accept && !go_split) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !cur_legal || mis_err;
        rsp_load  <= !req_we && cur_legal && !mis_err;
        rsp_size  <= req_size;
        rsp_lane  <= cur_l;
      end
    end
  end

  // Rotate the addressed lane to bit 0 and extend; zero for stores/errors.
  always_comb begin
    rd_dbl    = {bank_q, bank_q} >> {rsp_lane, 3'b000};
    rd_rot    = rd_dbl[31:0];
    rsp_rdata = '0;
    if (rsp_load) begin
      case (rsp_size)
        SZ_B:    rsp_rdata = {{24{rd_rot[7]}}, rd_rot[7:0]};
        SZ_H:    rsp_rdata = {{16{rd_rot[15]}}, rd_rot[15:0]};
        SZ_BU:   rsp_rdata = {24'd0, rd_rot[7:0]};
        SZ_HU:   rsp_rdata = {16'd0, rd_rot[15:0]};
        default: rsp_rdata = rd_rot;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed vector bench for data_memory_ctrl; MISALIGNED_EN selects the
// split-access sequences or the misaligned-error vectors.
module tb_data_memory_ctrl;

  localparam int DB = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_memory_ctrl #(.DATA_BYTES(DB), .INIT_PREFIX("")) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic e, input logic [31:0] rd,
                              input string nm);
    vec_t v;
    v.we = we; v.size = sz; v.addr = a; v.wdata = wd; v.err = e; v.rdata = rd; v.name = nm;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
  endtask

  task automatic check_rsp(input string nm, input logic e, input logic [31:0] rd);
    check({nm, " valid"}, {31'd0, rsp_valid}, 32'd1);
    check({nm, " err"},   {31'd0, rsp_err},   {31'd0, e});
    check({nm, " rdata"}, rsp_rdata, rd);
  endtask

  // Single-beat transaction, response expected one edge after accept.
  task automatic txn(input string nm, input logic we, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic e, input logic [31:0] rd);
    drive(we, sz, a, wd);
    check({nm, " ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_rsp(nm, e, rd);
  endtask

`ifdef MISALIGNED_EN
  // Word-crossing transaction: ready drops for one cycle, response one edge later.
  task automatic split_txn(input string nm, input logic we, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd);
    drive(we, sz, a, wd);
    check({nm, " ready0"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check({nm, " ready1"}, {31'd0, req_ready}, 32'd0);
    check({nm, " early"},  {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_rsp(nm, 1'b0, rd);
    check({nm, " ready2"}, {31'd0, req_ready}, 32'd1);
  endtask
`endif

  initial begin
    logic [31:0] last_exp;

    vecs.push_back(mk(1, 3'b010, 32'h00, 32'h0000_0000, 0, 32'h0, "clr0"));
    vecs.push_back(mk(1, 3'b010, 32'h20, 32'h0000_0000, 0, 32'h0, "clr20"));
    vecs.push_back(mk(1, 3'b010, 32'h10, 32'h80FF_7F01, 0, 32'h0, "sw10"));
    vecs.push_back(mk(0, 3'b000, 32'h11, 32'h0, 0, 32'h0000_007F, "lb11"));
    vecs.push_back(mk(0, 3'b100, 32'h13, 32'h0, 0, 32'h0000_0080, "lbu13"));
    vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 0, 32'h80FF_7F01, "lw10"));
    vecs.push_back(mk(0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFF_80FF, "lh12"));
    vecs.push_back(mk(0, 3'b101, 32'h12, 32'h0, 0, 32'h0000_80FF, "lhu12"));
    vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFF_FF80, "lb13"));
    vecs.push_back(mk(0, 3'b001, 32'h10, 32'h0, 0, 32'h0000_7F01, "lh10"));
    vecs.push_back(mk(1, 3'b001, 32'h21, 32'h0000_BEEF, 0, 32'h0, "sh21"));
    vecs.push_back(mk(0, 3'b001, 32'h21, 32'h0, 0, 32'hFFFF_BEEF, "lh21"));
    vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 0, 32'h00BE_EF00, "lw20a"));
    vecs.push_back(mk(1, 3'b000, 32'h23, 32'h1234_56A5, 0, 32'h0, "sb23"));
    vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 0, 32'hA5BE_EF00, "lw20b"));
    vecs.push_back(mk(0, 3'b100, 32'h22, 32'h0, 0, 32'h0000_00BE, "lbu22"));
    vecs.push_back(mk(1, 3'b011, 32'h00, 32'hFFFF_FFFF, 1, 32'h0, "ill011"));
    vecs.push_back(mk(0, 3'b010, 32'h00, 32'h0, 0, 32'h0, "lw0"));
    vecs.push_back(mk(0, 3'b110, 32'h10, 32'h0, 1, 32'h0, "ill110"));
    vecs.push_back(mk(0, 3'b111, 32'h10, 32'h0, 1, 32'h0, "ill111"));
    vecs.push_back(mk(0, 3'b010, 32'h0001_0010, 32'h0, 0, 32'h80FF_7F01, "lwhi"));
    vecs.push_back(mk(0, 3'b101, 32'h21, 32'h0, 0, 32'h0000_BEEF, "lhu21"));
`ifndef MISALIGNED_EN
    vecs.push_back(mk(0, 3'b010, 32'h02, 32'h0, 1, 32'h0, "mis_lw02"));
    vecs.push_back(mk(1, 3'b010, 32'h11, 32'hDEAD_BEEF, 1, 32'h0, "mis_sw11"));
    vecs.push_back(mk(1, 3'b001, 32'h23, 32'h0000_FFFF, 1, 32'h0, "mis_sh23"));
    vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 0, 32'h80FF_7F01, "lw10_keep"));
    vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 0, 32'hA5BE_EF00, "lw20_keep"));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rdata", rsp_rdata, 32'd0);
    check("rst err",   {31'd0, rsp_err},   32'd0);
    check("rst ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst valid", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back: a new request every cycle, each checked one edge later.
    last_exp = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, " ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      check_rsp(vecs[i].name, vecs[i].err, vecs[i].rdata);
      last_exp = vecs[i].rdata;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("idle valid", {31'd0, rsp_valid}, 32'd0);
    check("idle hold",  rsp_rdata, last_exp);

    // Async reset clears the response immediately.
    txn("lw10_pre_rst", 0, 3'b010, 32'h10, 32'h0, 0, 32'h80FF_7F01);
    rst = 1'b1;
    #1;
    check("async rst rdata", rsp_rdata, 32'd0);
    check("async rst valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef MISALIGNED_EN
    txn("sw1c", 1, 3'b010, 32'h1C, 32'h1234_5678, 0, 32'h0);
    split_txn("sw1e", 1, 3'b010, 32'h1E, 32'h4433_2211, 32'h0);
    txn("lw1c", 0, 3'b010, 32'h1C, 32'h0, 0, 32'h2211_5678);
    txn("lw20", 0, 3'b010, 32'h20, 32'h0, 0, 32'hA5BE_4433);
    split_txn("lw1e", 0, 3'b010, 32'h1E, 32'h0, 32'h4433_2211);
    split_txn("lh1f", 0, 3'b001, 32'h1F, 32'h0, 32'h0000_3322);
    txn("lh21_inword", 0, 3'b001, 32'h21, 32'h0, 0, 32'hFFFF_BE44);

    txn("clr_top", 1, 3'b010, DB - 4, 32'h0, 0, 32'h0);
    split_txn("sw_wrap", 1, 3'b010, DB - 2, 32'hCAFE_F00D, 32'h0);
    txn("lw_top", 0, 3'b010, DB - 4, 32'h0, 0, 32'hF00D_0000);
    txn("lw_w0", 0, 3'b010, 32'h0, 32'h0, 0, 32'h0000_CAFE);
    split_txn("lw_wrap", 0, 3'b010, DB - 2, 32'h0, 32'hCAFE_F00D);

    // Reset in SPLIT: first-beat lanes stay written, second beat is dropped.
    drive(1, 3'b010, DB - 2, 32'h9988_7766);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort valid0", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("abort valid1", {31'd0, rsp_valid}, 32'd0);
    check("abort ready1", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort valid2", {31'd0, rsp_valid}, 32'd0);
    txn("abort_w0", 0, 3'b010, 32'h0, 32'h0, 0, 32'h0000_CAFE);
    txn("abort_top", 0, 3'b010, DB - 4, 32'h0, 0, 32'h7766_0000);
`else
    txn("sw_top", 1, 3'b010, DB - 4, 32'hCAFE_F00D, 0, 32'h0);
    txn("lw_top_hi", 0, 3'b010, 32'hFFFF_FFFC, 32'h0, 0, 32'hCAFE_F00D);
    txn("lh_top", 0, 3'b001, DB - 2, 32'h0, 0, 32'hFFFF_CAFE);
    txn("mis_wrap", 1, 3'b010, DB - 2, 32'h1111_1111, 1, 32'h0);
    txn("lw_w0_keep", 0, 3'b010, 32'h0000_1000, 32'h0, 0, 32'h0);
    txn("lw_top_keep", 0, 3'b010, DB - 4, 32'h0, 0, 32'hCAFE_F00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
